id_ex_stage: RTL and testbench

- ID/EX pipeline stage, directly downstream of the decode control unit.
- Registers the decoded WB/M/EX control bundles, operands, immediate, register indices and shift info for the EX stage.
- Detects the load-use hazard and inserts a bubble while stalling PC and IF/ID.
- Handles a downstream memory stall (freeze) and a flush from later-stage redirect.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/hazard_detect.sv | 44 ++++
 rtl/id_ex_stage.sv | 215 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the MIPS datapath slice.
// Holds the control-bundle widths, the bit positions inside each bundle,
// the ALU opcode encodings and a helper that decides whether an
// instruction reads its rt register.
package mips_pkg;

  localparam int unsigned WB_W = 2;
  localparam int unsigned M_W  = 2;
  localparam int unsigned EX_W = 6;

  localparam int unsigned WB_REGWRITE    = 1;
  localparam int unsigned WB_MEMTOREG    = 0;
  localparam int unsigned M_MEMREAD      = 1;
  localparam int unsigned M_MEMWRITE     = 0;
  localparam int unsigned EX_REGDST      = 5;
  localparam int unsigned EX_ALUSRC      = 4;
  localparam int unsigned EX_ALUCTRL_MSB = 3;
  localparam int unsigned EX_ALUCTRL_LSB = 0;

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluSrl = 4'b0011,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluXor = 4'b1001,
    AluSll = 4'b1010,
    AluSra = 4'b1011,
    AluNor = 4'b1100
  } alu_op_e;

  // R-type (RegDst), stores and branches all consume rt as a source operand.
  function automatic logic rt_used(input logic regdst, input logic mem_write,
                                   input logic beq, input logic bne);
    return regdst | mem_write | beq | bne;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator for the ID/EX boundary.
// Inputs : ID instruction fields (valid, rs, rt, rt-use decode bits),
//          EX occupant (valid, MemRead, rt), mem_stall_i, flush_i.
// Outputs: lu_o (raw load-use hazard), pc_write_o, ifid_write_o
//          (0 = hold PC / IF/ID). Purely combinational.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_regdst_i,
  input  logic              id_mem_write_i,
  input  logic              id_beq_i,
  input  logic              id_bne_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  output logic              lu_o,
  output logic              pc_write_o,
  output logic              ifid_write_o
);

  logic load_in_ex;
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    // $0 is never a real dependency, so a load targeting it cannot hazard.
    load_in_ex = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0);
    rs_hit     = (ex_rt_i == id_rs_i);
    rt_hit     = (ex_rt_i == id_rt_i) &
                 rt_used(id_regdst_i, id_mem_write_i, id_beq_i, id_bne_i);
    lu_o       = id_valid_i & load_in_ex & (rs_hit | rt_hit);
    // A flush squashes ID upstream, so the hazard no longer needs a stall.
    pc_write_o   = ~mem_stall_i & (flush_i | ~lu_o);
    ifid_write_o = pc_write_o;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Ports: clk/rst (sync, active-high); id_* decoded ID instruction;
//        mem_stall (freeze), flush (squash); ex_* registered copies for EX;
//        pc_write / ifid_write (0 = hold) computed combinationally.
// Build option ID_EX_PERF_EN adds perf_stall_cnt and perf_bubble_cnt.
// Update priority per edge: rst > mem_stall > flush > load-use > load.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [WB_W-1:0]   id_wb,
  input  logic [M_W-1:0]    id_m,
  input  logic [EX_W-1:0]   id_ex,
  input  logic              id_beq,
  input  logic              id_bne,
  input  logic              id_shift,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_shamt,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [WB_W-1:0]   ex_wb,
  output logic [M_W-1:0]    ex_m,
  output logic [EX_W-1:0]   ex_ex,
  output logic              ex_shift,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_shamt,
  output logic              pc_write,
  output logic              ifid_write
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  logic lu;

  logic              valid_q, valid_d;
  logic [WB_W-1:0]   wb_q, wb_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [EX_W-1:0]   ex_q, ex_d;
  logic              shift_q, shift_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] shamt_q, shamt_d;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_regdst_i    (id_ex[EX_REGDST]),
    .id_mem_write_i (id_m[M_MEMWRITE]),
    .id_beq_i       (id_beq),
    .id_bne_i       (id_bne),
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (m_q[M_MEMREAD]),
    .ex_rt_i        (rt_q),
    .mem_stall_i    (mem_stall),
    .flush_i        (flush),
    .lu_o           (lu),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write)
  );

  always_comb begin
    valid_d   = valid_q;
    wb_d      = wb_q;
    m_d       = m_q;
    ex_d      = ex_q;
    shift_d   = shift_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    pc4_d     = pc4_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    shamt_d   = shamt_q;
    if (mem_stall) begin
      // Freeze: everything holds; a pending flush is re-presented later.
    end else if (flush || lu) begin
      // Bubble: clearing m also drops MemRead, so lu cannot repeat.
      valid_d   = 1'b0;
      wb_d      = '0;
      m_d       = '0;
      ex_d      = '0;
      shift_d   = 1'b0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      pc4_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      shamt_d   = '0;
    end else begin
      valid_d   = id_valid;
      // An invalid ID slot must never write the register file or memory.
      wb_d      = id_valid ? id_wb : '0;
      m_d       = id_valid ? id_m : '0;
      ex_d      = id_ex;
      shift_d   = id_shift;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      pc4_d     = id_pc4;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      shamt_d   = id_shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      wb_q      <= '0;
      m_q       <= '0;
      ex_q      <= '0;
      shift_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      wb_q      <= wb_d;
      m_q       <= m_d;
      ex_q      <= ex_d;
      shift_q   <= shift_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      pc4_q     <= pc4_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      shamt_q   <= shamt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_wb      = wb_q;
  assign ex_m       = m_q;
  assign ex_ex      = ex_q;
  assign ex_shift   = shift_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_shamt   = shamt_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (mem_stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else if (flush || lu) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model predicts the next
// EX register contents, pushes them to a scoreboard queue when the stimulus
// is driven, and pops/compares them after the clock edge.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [1:0]    id_wb, id_m;
  logic [5:0]    id_ex;
  logic          id_beq, id_bne, id_shift;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [AW-1:0] id_rs, id_rt, id_rd, id_shamt;
  logic          mem_stall, flush;
  logic          ex_valid;
  logic [1:0]    ex_wb, ex_m;
  logic [5:0]    ex_ex;
  logic          ex_shift;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd, ex_shamt;
  logic          pc_write, ifid_write;
`ifdef ID_EX_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_bubble_cnt;
  int unsigned   m_stall_cnt, m_bubble_cnt;
`endif

  typedef struct packed {
    logic          valid;
    logic [1:0]    wb;
    logic [1:0]    m;
    logic [5:0]    ex;
    logic          shift;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [AW-1:0] shamt;
  } ex_state_t;

  ex_state_t md;
  ex_state_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W(DW),
    .REG_AW(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_wb      (id_wb),
    .id_m       (id_m),
    .id_ex      (id_ex),
    .id_beq     (id_beq),
    .id_bne     (id_bne),
    .id_shift   (id_shift),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .id_pc4     (id_pc4),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_shamt   (id_shamt),
    .mem_stall  (mem_stall),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_wb      (ex_wb),
    .ex_m       (ex_m),
    .ex_ex      (ex_ex),
    .ex_shift   (ex_shift),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_imm     (ex_imm),
    .ex_pc4     (ex_pc4),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_shamt   (ex_shamt),
    .pc_write   (pc_write),
    .ifid_write (ifid_write)
`ifdef ID_EX_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  function automatic logic model_lu();
    logic rt_use;
    rt_use = id_ex[5] | id_m[0] | id_beq | id_bne;
    return id_valid & md.valid & md.m[1] & (md.rt != 5'd0) &
           ((md.rt == id_rs) | ((md.rt == id_rt) & rt_use));
  endfunction

  function automatic ex_state_t model_next(input logic lu_m);
    ex_state_t n;
    if (rst) begin
      n = '0;
    end else if (mem_stall) begin
      n = md;
    end else if (flush || lu_m) begin
      n = '0;
    end else begin
      n = '{valid: id_valid, wb: id_valid ? id_wb : 2'b00, m: id_valid ? id_m : 2'b00,
            ex: id_ex, shift: id_shift, rs_data: id_rs_data, rt_data: id_rt_data,
            imm: id_imm, pc4: id_pc4, rs: id_rs, rt: id_rt, rd: id_rd, shamt: id_shamt};
    end
    return n;
  endfunction

  // exp_pcw: 0/1 explicit, -1 skip the stall check, -2 take it from the model.
  task automatic cycle(input int exp_pcw, input string name);
    ex_state_t nxt, got, e;
    logic lu_m;
    logic pcw_e;
    #1;
    lu_m = model_lu();
    if (exp_pcw == -2) pcw_e = ~mem_stall & (flush | ~lu_m);
    else pcw_e = exp_pcw[0];
    if (exp_pcw != -1) begin
      n_cmp++;
      if (pc_write !== pcw_e || ifid_write !== pcw_e) begin
        n_err++;
        $display("FAIL %s stall: pc_write=%b ifid_write=%b required %b", name, pc_write,
                 ifid_write, pcw_e);
      end
    end
    nxt = model_next(lu_m);
    sb_q.push_back(nxt);
`ifdef ID_EX_PERF_EN
    if (rst) begin
      m_stall_cnt = 0;
      m_bubble_cnt = 0;
    end else if (mem_stall) m_stall_cnt++;
    else if (flush || lu_m) m_bubble_cnt++;
`endif
    @(posedge clk);
    #1;
    got = '{valid: ex_valid, wb: ex_wb, m: ex_m, ex: ex_ex, shift: ex_shift,
            rs_data: ex_rs_data, rt_data: ex_rt_data, imm: ex_imm, pc4: ex_pc4,
            rs: ex_rs, rt: ex_rt, rd: ex_rd, shamt: ex_shamt};
    e = sb_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s ex_regs: got %h required %h", name, got, e);
    end
    md = e;
  endtask

  task automatic set_instr(input logic v, input logic [1:0] wb, input logic [1:0] m,
                           input logic [5:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd);
    id_valid = v;
    id_wb = wb;
    id_m = m;
    id_ex = ex;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    id_beq = 1'b0;
    id_bne = 1'b0;
    id_shift = 1'b0;
    id_shamt = 5'd0;
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm = $urandom;
    id_pc4 = $urandom;
  endtask

  task automatic set_lw(input logic [4:0] rt, input logic [4:0] rs);
    set_instr(1'b1, 2'b11, 2'b10, 6'b010010, rs, rt, 5'd0);
  endtask
  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_instr(1'b1, 2'b10, 2'b00, 6'b100010, rs, rt, rd);
  endtask
  task automatic set_sw(input logic [4:0] rt, input logic [4:0] rs);
    set_instr(1'b1, 2'b00, 2'b01, 6'b010010, rs, rt, 5'd0);
  endtask
  task automatic set_addi(input logic [4:0] rt, input logic [4:0] rs);
    set_instr(1'b1, 2'b10, 2'b00, 6'b010010, rs, rt, 5'd0);
  endtask
  task automatic set_idle();
    set_instr(1'b0, 2'b00, 2'b00, 6'b000000, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic set_random();
    id_valid = ($urandom_range(0, 7) != 0);
    id_wb = 2'($urandom);
    id_m = 2'($urandom);
    id_ex = 6'($urandom);
    id_beq = ($urandom_range(0, 5) == 0);
    id_bne = ($urandom_range(0, 5) == 0);
    id_shift = 1'($urandom);
    id_rs = 5'($urandom_range(0, 7));
    id_rt = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom);
    id_shamt = 5'($urandom);
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm = $urandom;
    id_pc4 = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_stall = 1'b0;
    flush = 1'b0;
    set_random();
    cycle(-1, "reset_0");
    set_random();
    cycle(1, "reset_1");
    rst = 1'b0;
    set_idle();
    cycle(1, "reset_release");
  endtask

  task automatic test_pass_through();
    set_add(5'd3, 5'd1, 5'd2);
    cycle(1, "pass_add");
    n_cmp += 4;
    if (ex_ex !== 6'b100010) begin
      n_err++;
      $display("FAIL pass_ex: got %b required 100010", ex_ex);
    end
    if (ex_wb !== 2'b10) begin
      n_err++;
      $display("FAIL pass_wb: got %b required 10", ex_wb);
    end
    if (ex_rd !== 5'd3) begin
      n_err++;
      $display("FAIL pass_rd: got %0d required 3", ex_rd);
    end
    if (ex_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pass_valid: got %b required 1", ex_valid);
    end
  endtask

  task automatic test_load_use_rs();
    set_lw(5'd5, 5'd1);
    cycle(1, "lu_rs_lw");
    set_add(5'd6, 5'd5, 5'd2);
    cycle(0, "lu_rs_stall");
    n_cmp++;
    if ({ex_valid, ex_wb, ex_m} !== 5'b0) begin
      n_err++;
      $display("FAIL lu_rs_bubble: got %b required 00000", {ex_valid, ex_wb, ex_m});
    end
    cycle(1, "lu_rs_add");
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
      n_err++;
      $display("FAIL lu_rs_enter: got valid=%b rd=%0d required valid=1 rd=6", ex_valid, ex_rd);
    end
  endtask

  task automatic test_load_use_rt();
    set_lw(5'd5, 5'd1);
    cycle(1, "lu_rt_lw_a");
    set_sw(5'd5, 5'd7);
    cycle(0, "lu_rt_sw_stall");
    cycle(1, "lu_rt_sw_go");
    set_lw(5'd5, 5'd1);
    cycle(1, "lu_rt_lw_b");
    set_addi(5'd9, 5'd5);
    cycle(0, "lu_rt_addi_stall");
    cycle(1, "lu_rt_addi_go");
    set_lw(5'd0, 5'd1);
    cycle(1, "lu_r0_lw");
    set_add(5'd6, 5'd0, 5'd0);
    cycle(1, "lu_r0_nostall");
  endtask

  task automatic test_priority();
    set_lw(5'd5, 5'd1);
    cycle(1, "prio_lw");
    set_add(5'd6, 5'd5, 5'd2);
    flush = 1'b1;
    cycle(1, "prio_flush_lu");
    flush = 1'b0;
    set_lw(5'd4, 5'd1);
    cycle(1, "prio_lw4");
    set_add(5'd8, 5'd4, 5'd3);
    mem_stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, "prio_freeze");
    mem_stall = 1'b0;
    cycle(1, "prio_freeze_flush");
    n_cmp++;
    if (ex_valid !== 1'b0 || ex_m !== 2'b00) begin
      n_err++;
      $display("FAIL prio_bubble: got valid=%b m=%b required 0/00", ex_valid, ex_m);
    end
    flush = 1'b0;
    set_idle();
    cycle(1, "prio_idle");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      set_random();
      mem_stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle(-2, "random");
    end
    mem_stall = 1'b0;
    flush = 1'b0;
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    set_idle();
    cycle(-1, "perf_rst");
    rst = 1'b0;
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, "perf_stall");
    mem_stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_lw(5'd5, 5'd1);
      cycle(1, "perf_lw");
      set_add(5'd6, 5'd5, 5'd2);
      cycle(0, "perf_lu");
      cycle(1, "perf_add");
    end
    flush = 1'b1;
    cycle(1, "perf_flush");
    flush = 1'b0;
    n_cmp += 2;
    if (perf_stall_cnt !== 32'd4 || perf_stall_cnt !== m_stall_cnt) begin
      n_err++;
      $display("FAIL perf_stall_cnt: got %0d required 4", perf_stall_cnt);
    end
    if (perf_bubble_cnt !== 32'd3 || perf_bubble_cnt !== m_bubble_cnt) begin
      n_err++;
      $display("FAIL perf_bubble_cnt: got %0d required 3", perf_bubble_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_load_use_rs();
    test_load_use_rt();
    test_priority();
    test_back_to_back();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
